// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and encodings for the IF-stage fetch sequencer.
package fetch_ctrl_pkg;

  localparam int               FC_WORD         = 32;
  localparam int               FC_CNT_W        = 32;
  localparam int               FC_DRAIN_CYCLES = 4;
  localparam logic [31:0]      FC_HALT_INSN    = 32'hFFFF_FFFF;

  // PC source select; 2'b11 is never driven.
  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_JMP = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: arbitrates redirect / load-use stall / halt and runs
// the BOOT -> RUN -> DRAIN -> HALTED lifecycle. Pipeline-register controls
// are combinational from state + inputs; halted and cycle_cnt are registered.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               WORD         = FC_WORD,
  parameter logic [WORD-1:0]  HALT_INSN    = FC_HALT_INSN,
  parameter int               DRAIN_CYCLES = FC_DRAIN_CYCLES,
  parameter int               CNT_W        = FC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORD-1:0]  instruction,
  input  logic             branch_taken,
  input  logic             jump_taken,
  input  logic             load_use,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             state_q, state_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               halted_q, halted_d;
  pc_sel_e            pc_sel_c;
  logic               halt_seen;

  // A halt only counts when the fetched word is on the valid path, not in
  // the shadow cycle after BOOT or a redirect.
  assign halt_seen = (instruction == HALT_INSN) && fetch_valid_q;

  // Next-state and control-output decode with fixed priority in RUN.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    halted_d      = halted_q;
    pc_en         = 1'b0;
    pc_sel_c      = PC_SEL_SEQ;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b1;
    id_ex_bubble  = 1'b1;

    unique case (state_q)
      ST_BOOT: begin
        // PC held at 0, IF/ID flushed; first RUN cycle is a shadow cycle.
        state_d       = ST_RUN;
        fetch_valid_d = 1'b0;
      end

      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (jump_taken) begin
          pc_sel_c      = PC_SEL_JMP;
          pc_en         = 1'b1;
          if_id_en      = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b0;
          fetch_valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_sel_c      = PC_SEL_BR;
          pc_en         = 1'b1;
          if_id_en      = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b0;
          fetch_valid_d = 1'b0;
        end else if (load_use) begin
          // Hold PC and IF/ID, insert a bubble into ID/EX.
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          if_id_flush   = 1'b0;
          id_ex_bubble  = 1'b1;
        end else if (halt_seen) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b0;
          drain_cnt_d   = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d       = ST_DRAIN;
        end else begin
          pc_en         = 1'b1;
          if_id_en      = 1'b1;
          if_id_flush   = 1'b0;
          id_ex_bubble  = 1'b0;
          fetch_valid_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Let in-flight instructions retire; redirects and stalls are ignored.
        cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b0;
        if (drain_cnt_q == '0) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end

      ST_HALTED: begin
        // Absorbing; defaults already hold the pipeline frozen and bubbled.
      end

      default: state_d = ST_BOOT;
    endcase
  end

  assign pc_sel    = pc_sel_c;
  assign halted    = halted_q;
  assign cycle_cnt = cycle_cnt_q;

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= ST_BOOT;
      fetch_valid_q <= 1'b0;
      drain_cnt_q   <= '0;
      cycle_cnt_q   <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      halted_q      <= halted_d;
    end
  end

endmodule
